id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-select stage that feeds the ALU. Captures decoded operands and control from the decode stage and forwards results from EX/MEM and MEM/WB. Drives the ALU `A`, `B` and `Control_in` inputs, plus the control bits the downstream stages need. Also detects load-use hazards and inserts bubbles itself.

---
 rtl/id_ex_stage.sv | 168 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
// Optional feature macro: ID_EX_FORWARDING_EN (EX/MEM and MEM/WB bypass paths).
module id_ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alu_src,
    input  logic [3:0]      id_alu_ctrl,
    input  logic [3:0]      id_ctrl,
    input  logic [4:0]      exm_rd_addr,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [4:0]      mwb_rd_addr,
    input  logic            mwb_reg_write,
    input  logic [XLEN-1:0] mwb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd_addr,
    output logic [3:0]      ex_ctrl,
    output logic            hazard_stall
);

    localparam logic [3:0] ALU_ADD = 4'b0010;

    logic            valid_q,    valid_d;
    logic [4:0]      rs1_q,      rs1_d;
    logic [4:0]      rs2_q,      rs2_d;
    logic [4:0]      rd_q,       rd_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic            alu_src_q,  alu_src_d;
    logic [3:0]      alu_ctrl_q, alu_ctrl_d;
    logic [3:0]      ctrl_q,     ctrl_d;

    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic            load_use;

    always_comb begin
        valid_d    = valid_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        alu_src_d  = alu_src_q;
        alu_ctrl_d = alu_ctrl_q;
        ctrl_d     = ctrl_q;
        if (flush || (!stall && hazard_stall)) begin
            valid_d    = 1'b0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            alu_src_d  = 1'b0;
            alu_ctrl_d = ALU_ADD;
            ctrl_d     = '0;
        end else if (!stall) begin
            valid_d    = id_valid;
            rs1_d      = id_rs1_addr;
            rs2_d      = id_rs2_addr;
            rd_d       = id_rd_addr;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            alu_src_d  = id_alu_src;
            alu_ctrl_d = id_alu_ctrl;
            ctrl_d     = id_ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            alu_src_q  <= 1'b0;
            alu_ctrl_q <= '0;
            ctrl_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            alu_src_q  <= alu_src_d;
            alu_ctrl_q <= alu_ctrl_d;
            ctrl_q     <= ctrl_d;
        end
    end

    // ctrl_q[1] is mem_read, ctrl_q[0] is reg_write
    assign load_use = id_valid & valid_q & ctrl_q[1] & (rd_q != '0) &
                      ((rd_q == id_rs1_addr) | (rd_q == id_rs2_addr));

`ifdef ID_EX_FORWARDING_EN
    always_comb begin
        rs1_fwd = rs1_data_q;
        rs2_fwd = rs2_data_q;
        if (rs1_q != '0) begin
            if (exm_reg_write && (exm_rd_addr == rs1_q))
                rs1_fwd = exm_result;
            else if (mwb_reg_write && (mwb_rd_addr == rs1_q))
                rs1_fwd = mwb_result;
        end
        if (rs2_q != '0) begin
            if (exm_reg_write && (exm_rd_addr == rs2_q))
                rs2_fwd = exm_result;
            else if (mwb_reg_write && (mwb_rd_addr == rs2_q))
                rs2_fwd = mwb_result;
        end
    end

    assign hazard_stall = load_use;
`else
    function automatic logic raw_dep(input logic [4:0] a, input logic ex_wr,
                                     input logic [4:0] ex_rd, input logic exm_wr,
                                     input logic [4:0] exm_rd);
        return (a != '0) && ((ex_wr && (ex_rd == a)) || (exm_wr && (exm_rd == a)));
    endfunction

    logic ex_writes;
    logic unused_bypass;

    assign ex_writes = valid_q & ctrl_q[0];
    assign rs1_fwd   = rs1_data_q;
    assign rs2_fwd   = rs2_data_q;

    // Without bypass paths, any in-flight producer ahead of write-back must drain first
    assign hazard_stall = load_use |
        (id_valid & (raw_dep(id_rs1_addr, ex_writes, rd_q, exm_reg_write, exm_rd_addr) |
                     raw_dep(id_rs2_addr, ex_writes, rd_q, exm_reg_write, exm_rd_addr)));

    assign unused_bypass = ^{exm_result, mwb_rd_addr, mwb_reg_write, mwb_result, rs1_q, rs2_q};
`endif

    assign ex_valid      = valid_q;
    assign alu_a         = rs1_fwd;
    assign ex_store_data = rs2_fwd;
    assign alu_b         = alu_src_q ? imm_q : rs2_fwd;
    assign alu_ctrl      = alu_ctrl_q;
    assign ex_rd_addr    = rd_q;
    assign ex_ctrl       = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed table, corner sequences, random vs. model.
module tb_id_ex_stage;

    logic        clk, reset_n, stall, flush, id_valid;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_alu_src;
    logic [3:0]  id_alu_ctrl, id_ctrl;
    logic [4:0]  exm_rd_addr, mwb_rd_addr;
    logic        exm_reg_write, mwb_reg_write;
    logic [31:0] exm_result, mwb_result;
    logic        ex_valid, hazard_stall;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_ctrl, ex_ctrl;
    logic [4:0]  ex_rd_addr;

    int passed = 0;
    int total  = 0;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl), .id_ctrl(id_ctrl),
        .exm_rd_addr(exm_rd_addr), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .mwb_rd_addr(mwb_rd_addr), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_ctrl(ex_ctrl),
        .hazard_stall(hazard_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        src;
        logic [3:0]  actl, ctrl;
        logic        e_valid;
        logic [31:0] e_a, e_b, e_st;
        logic [3:0]  e_actl, e_ctrl;
        logic [4:0]  e_rd;
    } vec_t;

    // Reference view of the instruction sitting in EX
    typedef struct packed {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        src;
        logic [3:0]  actl, ctrl;
    } exi_t;

    localparam exi_t RESET_EXI  = '{1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0, 4'd0};
    localparam exi_t BUBBLE_EXI = '{1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd2, 4'd0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic src, input logic [3:0] actl,
                          input logic [3:0] ctrl);
        id_valid = v; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_src = src;
        id_alu_ctrl = actl; id_ctrl = ctrl;
    endtask

    task automatic bypass(input logic [4:0] erd, input logic ew, input logic [31:0] eres,
                          input logic [4:0] mrd, input logic mw, input logic [31:0] mres);
        exm_rd_addr = erd; exm_reg_write = ew; exm_result = eres;
        mwb_rd_addr = mrd; mwb_reg_write = mw; mwb_result = mres;
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] d);
`ifdef ID_EX_FORWARDING_EN
        if (a == 0) return d;
        if (exm_reg_write && exm_rd_addr == a) return exm_result;
        if (mwb_reg_write && mwb_rd_addr == a) return mwb_result;
`endif
        return d;
    endfunction

    function automatic logic ref_hazard(input exi_t m);
        logic [4:0] srcs [2];
        logic hz;
        srcs[0] = id_rs1_addr;
        srcs[1] = id_rs2_addr;
        hz = 1'b0;
        if (!id_valid) return 1'b0;
        foreach (srcs[k]) begin
            if (m.v && m.ctrl[1] && m.rd != 0 && m.rd == srcs[k]) hz = 1'b1;
`ifndef ID_EX_FORWARDING_EN
            if (srcs[k] != 0 && m.v && m.ctrl[0] && m.rd == srcs[k]) hz = 1'b1;
            if (srcs[k] != 0 && exm_reg_write && exm_rd_addr == srcs[k]) hz = 1'b1;
`endif
        end
        return hz;
    endfunction

    vec_t vecs [5];
    exi_t m;
    logic [31:0] e_st, e_b;
    logic        e_hz;
    logic [3:0]  actl_pick [4];

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bypass(0, 0, 0, 0, 0, 0);
        #3;
        chk("reset ex_valid", ex_valid, 0);
        chk("reset alu_a", alu_a, 0);
        chk("reset alu_b", alu_b, 0);
        chk("reset store", ex_store_data, 0);
        chk("reset alu_ctrl", alu_ctrl, 0);
        chk("reset ex_ctrl", ex_ctrl, 0);
        chk("reset hazard", hazard_stall, 0);
        reset_n = 1'b1;

        vecs[0] = '{1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 4'd2, 4'd1,
                    1'b1, 32'd5, 32'd7, 32'd7, 4'd2, 4'd1, 5'd3};
        vecs[1] = '{1'b1, 5'd4, 5'd5, 5'd6, 32'hA, 32'h55, 32'hFFFF_FFF0, 1'b1, 4'd1, 4'd1,
                    1'b1, 32'hA, 32'hFFFF_FFF0, 32'h55, 4'd1, 4'd1, 5'd6};
        vecs[2] = '{1'b0, 5'd13, 5'd14, 5'd12, 32'd1, 32'd2, 32'd0, 1'b0, 4'd0, 4'd1,
                    1'b0, 32'd1, 32'd2, 32'd2, 4'd0, 4'd1, 5'd12};
        vecs[3] = '{1'b1, 5'd8, 5'd9, 5'd7, 32'd100, 32'd30, 32'd0, 1'b0, 4'd6, 4'd1,
                    1'b1, 32'd100, 32'd30, 32'd30, 4'd6, 4'd1, 5'd7};
        vecs[4] = '{1'b1, 5'd10, 5'd11, 5'd0, 32'h2000, 32'hCAFE, 32'd8, 1'b1, 4'd2, 4'd2,
                    1'b1, 32'h2000, 32'd8, 32'hCAFE, 4'd2, 4'd2, 5'd0};
        foreach (vecs[i]) begin
            set_id(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].d1, vecs[i].d2,
                   vecs[i].imm, vecs[i].src, vecs[i].actl, vecs[i].ctrl);
            #1;
            chk($sformatf("vec%0d hazard", i), hazard_stall, 0);
            tick();
            chk($sformatf("vec%0d ex_valid", i), ex_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d alu_a", i), alu_a, vecs[i].e_a);
            chk($sformatf("vec%0d alu_b", i), alu_b, vecs[i].e_b);
            chk($sformatf("vec%0d store", i), ex_store_data, vecs[i].e_st);
            chk($sformatf("vec%0d alu_ctrl", i), alu_ctrl, vecs[i].e_actl);
            chk($sformatf("vec%0d ex_ctrl", i), ex_ctrl, vecs[i].e_ctrl);
            chk($sformatf("vec%0d ex_rd", i), ex_rd_addr, vecs[i].e_rd);
        end

        // Forwarding priority and the x0 exclusion
        set_id(1, 3, 0, 9, 32'h33, 0, 0, 0, 4'd2, 4'd1);
        tick();
        id_valid = 1'b0;
        bypass(3, 1, 32'h10, 3, 1, 32'h20);
        #1;
`ifdef ID_EX_FORWARDING_EN
        chk("fwd exm wins", alu_a, 32'h10);
`else
        chk("nofwd exm ignored", alu_a, 32'h33);
`endif
        exm_reg_write = 1'b0;
        #1;
`ifdef ID_EX_FORWARDING_EN
        chk("fwd mwb", alu_a, 32'h20);
`else
        chk("nofwd mwb ignored", alu_a, 32'h33);
`endif
        bypass(0, 0, 0, 0, 0, 0);
        set_id(1, 0, 0, 9, 32'h44, 32'h45, 0, 0, 4'd2, 4'd1);
        tick();
        id_valid = 1'b0;
        bypass(0, 1, 32'h99, 0, 1, 32'h77);
        #1;
        chk("x0 not forwarded a", alu_a, 32'h44);
        chk("x0 not forwarded st", ex_store_data, 32'h45);

        // Load-use: LW x4 then SUB x5,x4,x1
        bypass(0, 0, 0, 0, 0, 0);
        set_id(1, 2, 0, 4, 32'h100, 0, 32'd4, 1, 4'd2, 4'b1011);
        tick();
        set_id(1, 4, 1, 5, 0, 32'h11, 0, 0, 4'd6, 4'd1);
        #1;
        chk("load-use hazard", hazard_stall, 1);
        tick();
        bypass(4, 1, 32'h1234, 0, 0, 0);
        #1;
        chk("bubble ex_valid", ex_valid, 0);
        chk("bubble ex_ctrl", ex_ctrl, 0);
        chk("bubble alu_ctrl", alu_ctrl, 4'd2);
        chk("bubble ex_rd", ex_rd_addr, 0);
`ifdef ID_EX_FORWARDING_EN
        chk("load-use released", hazard_stall, 0);
        tick();
        bypass(0, 0, 0, 4, 1, 32'hBEEF);
`else
        chk("nofwd second stall", hazard_stall, 1);
        tick();
        bypass(0, 0, 0, 4, 1, 32'hBEEF);
        id_rs1_data = 32'hBEEF;
        #1;
        chk("nofwd second bubble", ex_valid, 0);
        chk("nofwd stall released", hazard_stall, 0);
        tick();
`endif
        #1;
        chk("sub issued valid", ex_valid, 1);
        chk("sub alu_a", alu_a, 32'hBEEF);
        chk("sub alu_b", alu_b, 32'h11);
        chk("sub alu_ctrl", alu_ctrl, 4'd6);
        chk("sub ex_rd", ex_rd_addr, 5);

        // Stall holds for 3 cycles, then flush beats stall
        bypass(0, 0, 0, 0, 0, 0);
        set_id(1, 6, 7, 8, 32'hAAAA, 32'hBBBB, 0, 0, 4'd1, 4'd1);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 5'(i + 10), 5'(i + 20), 5'(i + 1), $urandom, $urandom, $urandom, 1, 4'd6, 4'd9);
            tick();
            chk($sformatf("stall%0d alu_a", i), alu_a, 32'hAAAA);
            chk($sformatf("stall%0d alu_b", i), alu_b, 32'hBBBB);
            chk($sformatf("stall%0d ex_rd", i), ex_rd_addr, 8);
            chk($sformatf("stall%0d ex_ctrl", i), ex_ctrl, 4'd1);
        end
        flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
        #1;
        chk("flush ex_valid", ex_valid, 0);
        chk("flush ex_ctrl", ex_ctrl, 0);
        chk("flush alu_ctrl", alu_ctrl, 4'd2);
        chk("flush alu_a", alu_a, 0);
        chk("flush ex_rd", ex_rd_addr, 0);

`ifndef ID_EX_FORWARDING_EN
        // ADD x3 in EX, dependent decode waits until x3 reaches write-back
        set_id(1, 1, 2, 3, 32'd5, 32'd7, 0, 0, 4'd2, 4'd1);
        tick();
        set_id(1, 3, 1, 6, 32'd0, 32'd5, 0, 0, 4'd2, 4'd1);
        #1;
        chk("raw stall 1", hazard_stall, 1);
        tick();
        bypass(3, 1, 32'd12, 0, 0, 0);
        #1;
        chk("raw stall 2", hazard_stall, 1);
        chk("raw bubble 1", ex_valid, 0);
        tick();
        bypass(0, 0, 0, 3, 1, 32'd12);
        id_rs1_data = 32'd12;
        #1;
        chk("raw released", hazard_stall, 0);
        chk("raw bubble 2", ex_valid, 0);
        tick();
        chk("raw issue valid", ex_valid, 1);
        chk("raw issue alu_a", alu_a, 32'd12);
        chk("raw issue alu_b", alu_b, 32'd5);
        bypass(0, 0, 0, 0, 0, 0);
`endif

        // Asynchronous reset mid-stream
        set_id(1, 17, 18, 19, 32'h5, 32'h7, 32'h9, 1, 4'd6, 4'b1111);
        tick();
        id_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst ex_valid", ex_valid, 0);
        chk("async rst alu_a", alu_a, 0);
        chk("async rst alu_b", alu_b, 0);
        chk("async rst store", ex_store_data, 0);
        chk("async rst ex_ctrl", ex_ctrl, 0);
        chk("async rst alu_ctrl", alu_ctrl, 0);
        chk("async rst hazard", hazard_stall, 0);
        #2;
        reset_n = 1'b1;
        m = RESET_EXI;

        // Randomized run against the reference model
        actl_pick[0] = 4'd0; actl_pick[1] = 4'd1; actl_pick[2] = 4'd2; actl_pick[3] = 4'd6;
        for (int c = 0; c < 400; c++) begin
            set_id(($urandom % 4) != 0, 5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4),
                   $urandom, $urandom, $urandom, 1'($urandom), actl_pick[$urandom % 4],
                   4'($urandom));
            bypass(5'($urandom % 4), 1'($urandom), $urandom, 5'($urandom % 4), 1'($urandom),
                   $urandom);
            stall = ($urandom % 8) == 0;
            flush = ($urandom % 10) == 0;
            #1;
            e_st = ref_fwd(m.rs2, m.d2);
            e_b  = m.src ? m.imm : e_st;
            e_hz = ref_hazard(m);
            chk("rnd alu_a", alu_a, ref_fwd(m.rs1, m.d1));
            chk("rnd alu_b", alu_b, e_b);
            chk("rnd store", ex_store_data, e_st);
            chk("rnd ex_valid", ex_valid, m.v);
            chk("rnd alu_ctrl", alu_ctrl, m.actl);
            chk("rnd ex_ctrl", ex_ctrl, m.ctrl);
            chk("rnd ex_rd", ex_rd_addr, m.rd);
            chk("rnd hazard", hazard_stall, e_hz);
            if (flush)
                m = BUBBLE_EXI;
            else if (stall)
                m = m;
            else if (e_hz)
                m = BUBBLE_EXI;
            else
                m = '{id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data,
                      id_rs2_data, id_imm, id_alu_src, id_alu_ctrl, id_ctrl};
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
